// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: FSM states, ALU opcode
// encodings and the width of the execute-wait counter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MAX = OP_SRA;

    localparam int CNT_W = 4;

    // Anything above the last defined opcode is answered with an error.
    function automatic logic op_illegal(input logic [4:0] opcode);
        return opcode > OP_MAX;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// vector and the priority pointer; the pointer flips to the other requester
// after every accepted request so neither side waits more than one turn.
module rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] req_valid_i,
    output logic [1:0] ready_o,
    output logic       grant_idx_o,
    output logic       accept_o
);

    logic prio_q;
    logic prio_d;
    logic grant_idx;

    // A lone valid requester wins; on a tie or no request the pointer decides.
    always_comb begin
        grant_idx = prio_q;
        if (req_valid_i == 2'b01) begin
            grant_idx = 1'b0;
        end else if (req_valid_i == 2'b10) begin
            grant_idx = 1'b1;
        end
    end

    assign ready_o     = enable_i ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign accept_o    = |(req_valid_i & ready_o);
    assign grant_idx_o = grant_idx;
    assign prio_d      = accept_o ? ~grant_idx : prio_q;

    // Priority pointer register, cleared to requester 0 on reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. A request is accepted
// in IDLE, its operands are registered onto the ALU ports, a fixed number of
// EXEC cycles lets the ALU settle, and the sampled result is held in RESP
// until the owning requester takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and a requester may drop valid
// before the transfer without side effects.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_opA0,
    input  logic [31:0] req_opB0,
    input  logic [31:0] req_opA1,
    input  logic [31:0] req_opB1,
    input  logic [4:0]  req_opcode0,
    input  logic [4:0]  req_opcode1,
    input  logic [4:0]  req_shamt0,
    input  logic [4:0]  req_shamt1,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_isNotEqual,
    output logic        resp_isLessThan,
    output logic        resp_overflow,
    output logic        resp_err,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    input  logic        alu_isNotEqual,
    input  logic        alu_isLessThan,
    input  logic        alu_overflow
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q;
    logic              grant_idx;
    logic              accept;
    logic              capture;
    logic              resp_done;

    logic [31:0]       alu_a_q, alu_b_q;
    logic [4:0]        alu_op_q, alu_sh_q;
    logic [1:0]        resp_valid_q;
    logic [31:0]       resp_result_q;
    logic              resp_ne_q, resp_lt_q, resp_ov_q, resp_err_q;

    logic [31:0]       sel_a, sel_b;
    logic [4:0]        sel_op, sel_sh;

    rr_arbiter_2 u_arb (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .enable_i    (state_q == IDLE),
        .req_valid_i (req_valid),
        .ready_o     (req_ready),
        .grant_idx_o (grant_idx),
        .accept_o    (accept)
    );

    assign sel_a  = grant_idx ? req_opA1    : req_opA0;
    assign sel_b  = grant_idx ? req_opB1    : req_opB0;
    assign sel_op = grant_idx ? req_opcode1 : req_opcode0;
    assign sel_sh = grant_idx ? req_shamt1  : req_shamt0;

    // Next-state logic: accept, count down the ALU settle time, hold response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        resp_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    cnt_d   = CNT_LOAD;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    resp_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand capture on accept, result capture after the wait, response release.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            owner_q       <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            alu_sh_q      <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_ne_q     <= 1'b0;
            resp_lt_q     <= 1'b0;
            resp_ov_q     <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                owner_q  <= grant_idx;
                alu_a_q  <= sel_a;
                alu_b_q  <= sel_b;
                alu_op_q <= sel_op;
                alu_sh_q <= sel_sh;
            end
            if (capture) begin
                resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                if (op_illegal(alu_op_q)) begin
                    resp_result_q <= '0;
                    resp_ne_q     <= 1'b0;
                    resp_lt_q     <= 1'b0;
                    resp_ov_q     <= 1'b0;
                    resp_err_q    <= 1'b1;
                end else begin
                    resp_result_q <= alu_result;
                    resp_ne_q     <= alu_isNotEqual;
                    resp_lt_q     <= alu_isLessThan;
                    resp_ov_q     <= alu_overflow;
                    resp_err_q    <= 1'b0;
                end
            end else if (resp_done) begin
                resp_valid_q <= 2'b00;
            end
        end
    end

    assign alu_operandA    = alu_a_q;
    assign alu_operandB    = alu_b_q;
    assign alu_opcode      = alu_op_q;
    assign alu_shiftamt    = alu_sh_q;
    assign resp_valid      = resp_valid_q;
    assign resp_result     = resp_result_q;
    assign resp_isNotEqual = resp_ne_q;
    assign resp_isLessThan = resp_lt_q;
    assign resp_overflow   = resp_ov_q;
    assign resp_err        = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (latency 1 and 3), each driving a
// behavioural ALU, exercised by directed scenarios and a randomized run
// checked against a cycle-countdown reference model.
module tb_alu_share_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk;
    logic        rst_n       [2];
    logic [1:0]  req_valid   [2];
    logic [1:0]  req_ready   [2];
    logic [31:0] req_opA0    [2];
    logic [31:0] req_opB0    [2];
    logic [31:0] req_opA1    [2];
    logic [31:0] req_opB1    [2];
    logic [4:0]  req_opcode0 [2];
    logic [4:0]  req_opcode1 [2];
    logic [4:0]  req_shamt0  [2];
    logic [4:0]  req_shamt1  [2];
    logic [1:0]  resp_valid  [2];
    logic [1:0]  resp_ready  [2];
    logic [31:0] resp_result [2];
    logic        resp_ne     [2];
    logic        resp_lt     [2];
    logic        resp_ov     [2];
    logic        resp_err    [2];
    logic [31:0] alu_a       [2];
    logic [31:0] alu_b       [2];
    logic [4:0]  alu_op      [2];
    logic [4:0]  alu_sh      [2];
    logic [31:0] alu_res     [2];
    logic        alu_ne      [2];
    logic        alu_lt      [2];
    logic        alu_ov      [2];

    int n_tests;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    // Returns {isNotEqual, isLessThan, overflow, result}. Undefined opcodes
    // produce deliberately non-zero garbage so response masking is visible.
    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op, input logic [4:0] sh);
        logic [31:0] r;
        logic        ne, lt, ov;
        r  = '0;
        ne = 1'b0;
        lt = 1'b0;
        ov = 1'b0;
        case (op)
            5'd0: begin
                r  = a + b;
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd1: begin
                r  = a - b;
                ov = (a[31] != b[31]) && (r[31] != a[31]);
                ne = (a != b);
                lt = ($signed(a) < $signed(b));
            end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << sh;
            5'd5: r = $unsigned($signed(a) >>> sh);
            default: begin
                r  = a ^ b ^ 32'hA5A5_0001;
                ne = 1'b1;
                lt = 1'b1;
                ov = 1'b1;
            end
        endcase
        return {ne, lt, ov, r};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_alu
        assign {alu_ne[gi], alu_lt[gi], alu_ov[gi], alu_res[gi]} =
            alu_fn(alu_a[gi], alu_b[gi], alu_op[gi], alu_sh[gi]);
    end

    alu_share_arbiter #(.ALU_LATENCY(LAT0)) u_dut_l1 (
        .clock(clk), .reset_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_opA0(req_opA0[0]), .req_opB0(req_opB0[0]),
        .req_opA1(req_opA1[0]), .req_opB1(req_opB1[0]),
        .req_opcode0(req_opcode0[0]), .req_opcode1(req_opcode1[0]),
        .req_shamt0(req_shamt0[0]), .req_shamt1(req_shamt1[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_result(resp_result[0]), .resp_isNotEqual(resp_ne[0]),
        .resp_isLessThan(resp_lt[0]), .resp_overflow(resp_ov[0]), .resp_err(resp_err[0]),
        .alu_operandA(alu_a[0]), .alu_operandB(alu_b[0]),
        .alu_opcode(alu_op[0]), .alu_shiftamt(alu_sh[0]),
        .alu_result(alu_res[0]), .alu_isNotEqual(alu_ne[0]),
        .alu_isLessThan(alu_lt[0]), .alu_overflow(alu_ov[0])
    );

    alu_share_arbiter #(.ALU_LATENCY(LAT1)) u_dut_l3 (
        .clock(clk), .reset_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_opA0(req_opA0[1]), .req_opB0(req_opB0[1]),
        .req_opA1(req_opA1[1]), .req_opB1(req_opB1[1]),
        .req_opcode0(req_opcode0[1]), .req_opcode1(req_opcode1[1]),
        .req_shamt0(req_shamt0[1]), .req_shamt1(req_shamt1[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_result(resp_result[1]), .resp_isNotEqual(resp_ne[1]),
        .resp_isLessThan(resp_lt[1]), .resp_overflow(resp_ov[1]), .resp_err(resp_err[1]),
        .alu_operandA(alu_a[1]), .alu_operandB(alu_b[1]),
        .alu_opcode(alu_op[1]), .alu_shiftamt(alu_sh[1]),
        .alu_result(alu_res[1]), .alu_isNotEqual(alu_ne[1]),
        .alu_isLessThan(alu_lt[1]), .alu_overflow(alu_ov[1])
    );

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d]      = 1'b0;
        req_valid[d]  = 2'b00;
        resp_ready[d] = 2'b00;
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b1;
    endtask

    task automatic set_req(input int d, input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [4:0] sh);
        if (r == 0) begin
            req_opA0[d] = a; req_opB0[d] = b; req_opcode0[d] = op; req_shamt0[d] = sh;
        end else begin
            req_opA1[d] = a; req_opB1[d] = b; req_opcode1[d] = op; req_shamt1[d] = sh;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_req(input int d, input int r);
        logic [4:0] op;
        if ($urandom_range(0, 9) > 7) op = 5'($urandom_range(0, 31));
        else                          op = 5'($urandom_range(0, 5));
        set_req(d, r, pick_operand(), pick_operand(), op, 5'($urandom_range(0, 31)));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset(input int d);
        do_reset(d);
        #1;
        n_tests++;
        if (req_ready[d] !== 2'b01) begin
            n_fail++; $display("FAIL reset_req_ready[%0d]: got %b expected 01", d, req_ready[d]);
        end
        n_tests++;
        if (resp_valid[d] !== 2'b00) begin
            n_fail++; $display("FAIL reset_resp_valid[%0d]: got %b expected 00", d, resp_valid[d]);
        end
        n_tests++;
        if ({resp_err[d], resp_ne[d], resp_lt[d], resp_ov[d], resp_result[d]} !== 36'd0) begin
            n_fail++; $display("FAIL reset_resp_data[%0d]: got %h expected 0", d, resp_result[d]);
        end
        n_tests++;
        if ({alu_a[d], alu_b[d], alu_op[d], alu_sh[d]} !== 74'd0) begin
            n_fail++; $display("FAIL reset_alu_regs[%0d]: got A=%h B=%h op=%h expected 0", d, alu_a[d], alu_b[d], alu_op[d]);
        end
    endtask

    task automatic test_single();
        do_reset(0);
        set_req(0, 0, 32'd7, 32'd5, 5'd0, 5'd0);
        req_valid[0] = 2'b01;
        #1;
        n_tests++;
        if (req_ready[0] !== 2'b01) begin
            n_fail++; $display("FAIL single_req_ready: got %b expected 01", req_ready[0]);
        end
        @(negedge clk);
        req_valid[0] = 2'b00;
        #1;
        n_tests++;
        if ({req_ready[0], resp_valid[0]} !== 4'b0000) begin
            n_fail++; $display("FAIL single_exec_handshakes: got ready=%b rv=%b expected 00/00", req_ready[0], resp_valid[0]);
        end
        n_tests++;
        if ({alu_a[0], alu_b[0], alu_op[0]} !== {32'd7, 32'd5, 5'd0}) begin
            n_fail++; $display("FAIL single_alu_ports: got A=%h B=%h op=%h expected 7/5/0", alu_a[0], alu_b[0], alu_op[0]);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (resp_valid[0] !== 2'b01) begin
            n_fail++; $display("FAIL single_resp_valid: got %b expected 01", resp_valid[0]);
        end
        n_tests++;
        if ({resp_err[0], resp_ne[0], resp_lt[0], resp_ov[0], resp_result[0]} !== {4'b0000, 32'd12}) begin
            n_fail++; $display("FAIL single_resp_data: got err=%b flags=%b%b%b res=%h expected 0/000/0000000c",
                               resp_err[0], resp_ne[0], resp_lt[0], resp_ov[0], resp_result[0]);
        end
        resp_ready[0] = 2'b01;
        @(negedge clk);
        #1;
        n_tests++;
        if ({resp_valid[0], req_ready[0]} !== {2'b00, 2'b10}) begin
            n_fail++; $display("FAIL single_after_handshake: got rv=%b ready=%b expected 00/10", resp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_contention();
        logic grants[$];
        int   n_r1;
        int   cyc;
        do_reset(0);
        set_req(0, 0, 32'd7, 32'd5, 5'd0, 5'd0);
        set_req(0, 1, 32'd3, 32'd9, 5'd1, 5'd0);
        req_valid[0]  = 2'b11;
        resp_ready[0] = 2'b11;
        n_r1 = 0;
        cyc  = 0;
        while (grants.size() < 4 && cyc < 60) begin
            #1;
            if ((req_ready[0] & req_valid[0]) == 2'b01) grants.push_back(1'b0);
            else if ((req_ready[0] & req_valid[0]) == 2'b10) grants.push_back(1'b1);
            if (resp_valid[0] == 2'b10) begin
                n_r1++;
                n_tests++;
                if ({resp_err[0], resp_ne[0], resp_lt[0], resp_ov[0], resp_result[0]} !== {4'b0110, 32'hFFFF_FFFA}) begin
                    n_fail++; $display("FAIL contention_sub_resp: got err=%b ne=%b lt=%b ov=%b res=%h expected 0/1/1/0/fffffffa",
                                       resp_err[0], resp_ne[0], resp_lt[0], resp_ov[0], resp_result[0]);
                end
            end else if (resp_valid[0] == 2'b01) begin
                n_tests++;
                if (resp_result[0] !== 32'd12) begin
                    n_fail++; $display("FAIL contention_add_resp: got %h expected 0000000c", resp_result[0]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid[0] = 2'b00;
        n_tests++;
        if (grants.size() != 4) begin
            n_fail++; $display("FAIL contention_grant_count: got %0d expected 4", grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            n_tests++;
            if (grants[i] !== (i % 2 == 1)) begin
                n_fail++; $display("FAIL contention_grant_order[%0d]: got %b expected %0d", i, grants[i], i % 2);
            end
        end
        n_tests++;
        if (n_r1 == 0) begin
            n_fail++; $display("FAIL contention_r1_served: got 0 responses expected at least 1");
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit got;
        do_reset(0);
        set_req(0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd2, 5'd0);
        req_valid[0] = 2'b01;
        @(negedge clk);
        set_req(0, 1, 32'd1, 32'd2, 5'd3, 5'd0);
        req_valid[0] = 2'b11;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid[0] != 2'b00) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL bp_resp_timeout: got no resp_valid expected within 10 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({resp_valid[0], req_ready[0], resp_result[0]} !== {2'b01, 2'b00, 32'hF000_F000}) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got rv=%b ready=%b res=%h expected 01/00/f000f000",
                                   i, resp_valid[0], req_ready[0], resp_result[0]);
            end
            @(negedge clk);
            #1;
        end
        resp_ready[0] = 2'b01;
        @(negedge clk);
        #1;
        n_tests++;
        if ({resp_valid[0], req_ready[0]} !== {2'b00, 2'b10}) begin
            n_fail++; $display("FAIL bp_release: got rv=%b ready=%b expected 00/10", resp_valid[0], req_ready[0]);
        end
        req_valid[0] = 2'b00;
    endtask

    task automatic test_illegal();
        bit got;
        do_reset(0);
        set_req(0, 1, 32'h1234_5678, 32'h0F0F_0F0F, 5'b00111, 5'd3);
        req_valid[0] = 2'b10;
        @(negedge clk);
        req_valid[0] = 2'b00;
        #1;
        n_tests++;
        if (alu_op[0] !== 5'b00111) begin
            n_fail++; $display("FAIL illegal_opcode_passthrough: got %b expected 00111", alu_op[0]);
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid[0] != 2'b00) got = 1'b1;
        end
        n_tests++;
        if (!got || resp_valid[0] !== 2'b10) begin
            n_fail++; $display("FAIL illegal_resp_valid: got %b expected 10", resp_valid[0]);
        end
        n_tests++;
        if ({resp_err[0], resp_ne[0], resp_lt[0], resp_ov[0], resp_result[0]} !== {4'b1000, 32'd0}) begin
            n_fail++; $display("FAIL illegal_resp_data: got err=%b flags=%b%b%b res=%h expected 1/000/0",
                               resp_err[0], resp_ne[0], resp_lt[0], resp_ov[0], resp_result[0]);
        end
        resp_ready[0] = 2'b11;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        do_reset(1);
        set_req(1, 0, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
        req_valid[1] = 2'b01;
        @(negedge clk);
        req_valid[1] = 2'b00;
        for (int i = 0; i < LAT1; i++) begin
            #1;
            n_tests++;
            if ({resp_valid[1], alu_a[1], alu_b[1], alu_op[1]} !== {2'b00, 32'h7FFF_FFFF, 32'd1, 5'd0}) begin
                n_fail++; $display("FAIL latency_exec[%0d]: got rv=%b A=%h B=%h op=%h expected 00/7fffffff/1/0",
                                   i, resp_valid[1], alu_a[1], alu_b[1], alu_op[1]);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (resp_valid[1] !== 2'b01) begin
            n_fail++; $display("FAIL latency_resp_valid: got %b expected 01", resp_valid[1]);
        end
        n_tests++;
        if ({resp_err[1], resp_ne[1], resp_lt[1], resp_ov[1], resp_result[1]} !== {4'b0001, 32'h8000_0000}) begin
            n_fail++; $display("FAIL latency_overflow: got err=%b ne=%b lt=%b ov=%b res=%h expected 0/0/0/1/80000000",
                               resp_err[1], resp_ne[1], resp_lt[1], resp_ov[1], resp_result[1]);
        end
        resp_ready[1] = 2'b01;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        set_req(1, 0, 32'hDEAD_0000, 32'h0000_BEEF, 5'd3, 5'd9);
        req_valid[1] = 2'b01;
        @(negedge clk);
        req_valid[1] = 2'b00;
        rst_n[1]     = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if ({alu_a[1], alu_b[1], alu_op[1], alu_sh[1]} !== 74'd0) begin
            n_fail++; $display("FAIL midreset_alu_regs: got A=%h B=%h op=%h sh=%h expected 0", alu_a[1], alu_b[1], alu_op[1], alu_sh[1]);
        end
        n_tests++;
        if ({resp_valid[1], resp_err[1], resp_ne[1], resp_lt[1], resp_ov[1], resp_result[1]} !== 38'd0) begin
            n_fail++; $display("FAIL midreset_resp: got rv=%b res=%h expected 00/0", resp_valid[1], resp_result[1]);
        end
        n_tests++;
        if (req_ready[1] !== 2'b01) begin
            n_fail++; $display("FAIL midreset_idle: got ready=%b expected 01", req_ready[1]);
        end
        rst_n[1] = 1'b1;
        resp_ready[1] = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (resp_valid[1] !== 2'b00) begin
                n_fail++; $display("FAIL midreset_no_resp[%0d]: got %b expected 00", i, resp_valid[1]);
            end
        end
        req_valid[1] = 2'b11;
        #1;
        n_tests++;
        if (req_ready[1] !== 2'b01) begin
            n_fail++; $display("FAIL midreset_prio: got ready=%b expected 01", req_ready[1]);
        end
        req_valid[1] = 2'b00;
    endtask

    // Randomized traffic against a countdown model: a request accepted while
    // the block is free makes the response appear lat edges later, and the
    // block is free again after the owner takes it.
    task automatic test_random(input int d, input int lat, input int ncyc);
        logic [36:0] exp_q[$];
        int          m_wait;
        bit          m_pend;
        logic        m_prio;
        logic        g;
        int          last_acc;
        logic [31:0] ma, mb;
        logic [4:0]  mop, msh;
        logic [1:0]  exp_rdy, exp_rv;
        logic [34:0] f;
        do_reset(d);
        m_wait = 0; m_pend = 1'b0; m_prio = 1'b0; last_acc = -1;
        ma = '0; mb = '0; mop = '0; msh = '0; g = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (last_acc >= 0) req_valid[d][last_acc] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[d][r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_req(d, r);
                        req_valid[d][r] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[d][r] = 1'b0;
                end
            end
            resp_ready[d] = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            #1;
            exp_rdy = 2'b00;
            if (m_wait == 0 && !m_pend) begin
                if (req_valid[d] == 2'b01)      g = 1'b0;
                else if (req_valid[d] == 2'b10) g = 1'b1;
                else                            g = m_prio;
                exp_rdy = g ? 2'b10 : 2'b01;
            end
            exp_rv = m_pend ? (exp_q[0][36] ? 2'b10 : 2'b01) : 2'b00;
            n_tests++;
            if (req_ready[d] !== exp_rdy) begin
                n_fail++; $display("FAIL rand%0d_req_ready@%0d: got %b expected %b", d, c, req_ready[d], exp_rdy);
            end
            n_tests++;
            if (resp_valid[d] !== exp_rv) begin
                n_fail++; $display("FAIL rand%0d_resp_valid@%0d: got %b expected %b", d, c, resp_valid[d], exp_rv);
            end
            if (m_pend) begin
                n_tests++;
                if ({resp_err[d], resp_ne[d], resp_lt[d], resp_ov[d], resp_result[d]} !== exp_q[0][35:0]) begin
                    n_fail++; $display("FAIL rand%0d_resp_data@%0d: got %h expected %h", d, c,
                                       {resp_err[d], resp_ne[d], resp_lt[d], resp_ov[d], resp_result[d]}, exp_q[0][35:0]);
                end
            end
            n_tests++;
            if ({alu_a[d], alu_b[d], alu_op[d], alu_sh[d]} !== {ma, mb, mop, msh}) begin
                n_fail++; $display("FAIL rand%0d_alu_ports@%0d: got %h/%h/%h/%h expected %h/%h/%h/%h", d, c,
                                   alu_a[d], alu_b[d], alu_op[d], alu_sh[d], ma, mb, mop, msh);
            end
            last_acc = -1;
            if (m_wait == 0 && !m_pend) begin
                if (req_valid[d][g]) begin
                    if (g) begin
                        ma = req_opA1[d]; mb = req_opB1[d]; mop = req_opcode1[d]; msh = req_shamt1[d];
                    end else begin
                        ma = req_opA0[d]; mb = req_opB0[d]; mop = req_opcode0[d]; msh = req_shamt0[d];
                    end
                    f = alu_fn(ma, mb, mop, msh);
                    if (mop > 5'd5) exp_q.push_back({g, 1'b1, 35'd0});
                    else            exp_q.push_back({g, 1'b0, f});
                    m_wait   = lat;
                    m_prio   = ~g;
                    last_acc = g ? 1 : 0;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_pend = 1'b1;
            end else if (resp_ready[d][exp_q[0][36]]) begin
                void'(exp_q.pop_front());
                m_pend = 1'b0;
            end
        end
        @(negedge clk);
        req_valid[d] = 2'b00;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 2'b00; resp_ready[d] = 2'b00;
            req_opA0[d] = '0; req_opB0[d] = '0; req_opA1[d] = '0; req_opB1[d] = '0;
            req_opcode0[d] = '0; req_opcode1[d] = '0; req_shamt0[d] = '0; req_shamt1[d] = '0;
        end
        test_reset(0);
        test_reset(1);
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_latency();
        test_reset_mid();
        test_random(0, LAT0, 400);
        test_random(1, LAT1, 400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got time limit reached expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational `alu` between two requesters, for example the execute stage and the multiply/divide sequencer, so that only one ALU instance is needed. Each requester issues its operation on a valid/ready channel and gets back the result and flags on its own valid/ready channel. Inside, the block does round-robin arbitration, registers the operands and runs a fixed-latency execute wait. It then holds each response until that requester accepts it. It sits between the requesters and the ALU ports (`data_operandA/B`, `ctrl_ALUopcode`, `ctrl_shiftamt`, `data_result`, `isNotEqual`, `isLessThan`, `overflow`).

## Interface
- `ALU_LATENCY`, default 1: cycles allowed for the ALU path before the result is sampled. Legal range is 1..15.
- `clock` in 1: the single clock. Every flop updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset, sampled on the `clock` rising edge.
- `req_valid[1:0]` in 2: per-requester request valid.
- `req_ready[1:0]` out 2: per-requester request ready.
- `req_opA0`, `req_opB0`, `req_opA1`, `req_opB1` in 32: operands.
- `req_opcode0`, `req_opcode1` in 5: ALU opcode.
- `req_shamt0`, `req_shamt1` in 5: shift amount.
- `resp_valid[1:0]` out 2: per-requester response valid.
- `resp_ready[1:0]` in 2: per-requester response ready.
- `resp_result` out 32: result, shared by both response channels and qualified by `resp_valid`.
- `resp_isNotEqual`, `resp_isLessThan`, `resp_overflow` out 1: flags, qualified the same way.
- `resp_err` out 1: set when the opcode was illegal, i.e. greater than 5'b00101.
- `alu_operandA`, `alu_operandB` out 32; `alu_opcode` out 5; `alu_shiftamt` out 5: drive the ALU.
- `alu_result` in 32; `alu_isNotEqual`, `alu_isLessThan`, `alu_overflow` in 1: ALU outputs.

## Operation
- **State machine:** IDLE -> EXEC -> RESP -> IDLE.
- **IDLE, arbitration:**
  - `req_ready[g]` = 1 only for the granted requester g; the other ready bit is 0.
  - If one requester is valid, it is granted.
  - If both are valid, the requester selected by priority pointer `prio` is granted.
  - With no valid request, the ready bit of requester `prio` is high.
- **IDLE, accept:**
  - On `req_valid[g] & req_ready[g]`, the operands, opcode, shift amount and `owner`=g are captured into the `alu_*` registers.
  - `prio` is set to ~g.
  - The wait counter is loaded with `ALU_LATENCY`-1 and the state goes to EXEC.
- **EXEC:** `alu_*` outputs stay stable. The counter decrements each cycle. When the counter is 0, the ALU outputs are captured into the `resp_*` registers and the state goes to RESP.
- **Illegal opcodes:** the opcode is still passed to the ALU. At capture, `resp_result` and all three flags are forced to 0 and `resp_err`=1.
- **Legal opcodes:** `resp_err`=0 and the ALU values are copied unchanged. `resp_isNotEqual` and `resp_isLessThan` are meaningful only for SUB, but are passed through for every opcode.
- **RESP:**
  - `resp_valid[owner]`=1 and the other bit is 0.
  - `resp_*` values are held until `resp_ready[owner]` is high at an edge, then the state returns to IDLE.
  - `req_ready` = 2'b00 while in EXEC and RESP.
- **Reset:** `reset_n`=0 at any edge, including mid-operation:
  - the in-flight transaction is discarded and never answered;
  - the state goes to IDLE and `prio` is set to 0;
  - all `alu_*`, `resp_*` and `resp_valid` outputs go to 0, and the counter goes to 0.

## Timing
- `req_ready` is combinational from the state, `prio` and `req_valid`. All other outputs are registered.
- A request accepted at edge k gives:
  - `alu_*` valid after edge k;
  - response captured at edge k+`ALU_LATENCY`;
  - `resp_valid` high from edge k+`ALU_LATENCY` onward.
- With `resp_ready` held high, the handshake completes at edge k+`ALU_LATENCY`+1.
- The next accept can happen at edge k+`ALU_LATENCY`+2, so peak throughput is one operation per `ALU_LATENCY`+2 cycles.
- **Simultaneous requests:** a winner held valid is served exactly once. The loser is served next if it is still valid, so neither requester waits more than one transaction.
- **Withdrawn requests:** dropping `req_valid` before the handshake is allowed. Nothing is captured.
- **Counter width:** 4 bits. `ALU_LATENCY`=1 gives exactly one EXEC cycle.

## Structure
- **Package `alu_arb_pkg`:**
  - state enum (IDLE, EXEC, RESP);
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SLL=4, OP_SRA=5;
  - OP_MAX=5 and the counter width.
- **Sub-module `rr_arbiter_2`:** combinational two-way round-robin grant from `req_valid` and `prio`, plus the registered pointer update on accept.

## Test plan
- **Single request:** after reset, req0 ADD A=32'd7, B=32'd5, `ALU_LATENCY`=1 -> `req_ready`=2'b01. `resp_valid`=2'b01 one edge after accept with `resp_result`=12, flags 0 and `resp_err`=0.
- **Contention:** both requesters valid continuously, `prio`=0 -> grants alternate 0,1,0,1. req1 SUB A=3, B=9 returns `resp_result`=32'hFFFFFFFA, isLessThan=1, isNotEqual=1.
- **Response back-pressure:** `resp_ready`=0 for 5 cycles -> `resp_valid` and `resp_result` held constant and `req_ready`=0 throughout. IDLE is entered on the first edge where `resp_ready` is high.
- **Illegal opcode:** opcode 5'b00111 -> `resp_err`=1, `resp_result`=0, all flags 0.
- **Latency and overflow:** `ALU_LATENCY`=3, ADD 32'h7FFFFFFF+1 -> `resp_valid` rises 3 edges after accept with `resp_result`=32'h80000000, overflow=1. `alu_*` stays stable through all EXEC cycles.
- **Reset mid-operation:** `reset_n`=0 during EXEC -> next cycle all outputs are 0, state is IDLE and no response is issued. The next request is served with `prio`=0.
